sonar_grid_reporter: RTL and testbench
======================================

# sonar_grid_reporter

Consumer stage directly downstream of the sonar ranging FSM. Watches its ASCII grid code (0x30 = nothing, 0x31–0x34 = grid 1–4) and detects each new measurement. Requires CONFIRM_COUNT consecutive identical measurements before accepting a grid. Publishes the accepted grid to the robot controller and reports it over an 8N1 UART as the digit followed by line feed (0x0A).

## Interface
- CLKS_PER_BIT, default 868 — clock cycles per UART bit (100 MHz / 115200).
- CONFIRM_COUNT, default 3 — consecutive equal measurements required to accept (legal 1–15).
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset; one clock domain.
- check_distance  input  8  ASCII grid code from sonar stage.
- grid  output  3  last accepted grid, 1–4; 0 before first acceptance.
- grid_valid  output  1  one-cycle pulse when grid is (re)accepted.
- tx  output  1  UART serial line, idle high.
- tx_busy  output  1  high while a report frame pair is being shifted out.

## Operation
- Input register prev_code holds check_distance from the previous cycle; reset value 0x30.
- Measurement event when prev_code == 0x30 and check_distance is in 0x31–0x34.
  - One event per 0x30→digit transition; a held digit is not re-counted.
  - A digit→different-digit transition without passing through 0x30 is not an event.
  - Codes outside 0x30–0x34 are ignored and do not update prev_code comparisons as events.
- Filter: candidate register cand (8 bits, reset 0x30) and counter match_cnt (4 bits, reset 0, saturates at CONFIRM_COUNT).
  - Event with code == cand: match_cnt += 1 (saturating).
  - Event with code != cand: cand <= code, match_cnt <= 1.
  - Accept when post-update match_cnt == CONFIRM_COUNT. Every further matching event after saturation also accepts, giving a periodic report.
- On accept:
  - grid <= code − 0x30 (low 3 bits).
  - grid_valid pulses.
  - Code is written into the 1-deep pending register; pend_valid is set.
- TX FSM states:
  - IDLE: tx=1. Leave when pend_valid; load shift byte from pending, clear pend_valid, byte_idx=0, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, go DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles, bit_idx 0–7, go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_idx==0: load 0x0A, byte_idx=1, go START. Otherwise go IDLE.
- tx_busy = (state != IDLE).
- Accept while busy overwrites pending (latest value wins, no queue). The frame in flight is never altered.
- Accept in the same cycle the FSM consumes pending: the new value stays pending (set wins over clear).
- Reset assertion mid-frame: tx returns to 1 immediately (asynchronous). All registers return to reset values. A partial frame is abandoned, never resumed.

## Timing
- Reset values: grid=0, grid_valid=0, tx=1, tx_busy=0, FSM IDLE, pend_valid=0.
- Event edge: check_distance changes before clock edge N, so prev_code differs at edge N. The filter updates at edge N+1; grid and grid_valid are visible after edge N+1.
- tx falls (start bit) on edge N+2 when FSM idle.
- Byte length 10·CLKS_PER_BIT cycles. Full report (digit + LF) 20·CLKS_PER_BIT cycles, back-to-back with no idle gap between bytes.
- Bit counter: 0 to CLKS_PER_BIT−1, wrap starts next bit; width clog2(CLKS_PER_BIT).
- Returning to IDLE with pend_valid set starts the next report on the following cycle (one idle-high cycle minimum).

## Test plan
- Reset, CLKS_PER_BIT=4, CONFIRM_COUNT=3: three pulses 0x30→0x32→0x30 → grid=2 and grid_valid pulse after third event only. tx frames 0x32 then 0x0A over 80 cycles, LSB first, stop bits high.
- Events 0x31, 0x31, 0x33, 0x33, 0x33 → no accept until fifth event; grid=3; earlier 0x31s produce no tx activity.
- Hold check_distance=0x34 for 500 cycles after one event → counts as exactly one event; no repeated counting.
- Fourth matching 0x32 event during an in-flight report, then 0x33×3 while still busy → after current LF, exactly one more report, carrying 0x33 (overwrite). Total two reports.
- Input 0x35 and 0xFF between events → ignored; match_cnt and cand unchanged.
- Assert reset at cycle 20 of a frame → tx=1 and grid=0 the same cycle. After release, no residual frame; the next three 0x31 events produce a clean report.

Source files
------------

// File: rtl/sonar_grid_reporter_if.sv
// sonar_grid_reporter_if: grid code input and grid/UART report outputs of the sonar grid reporter
interface sonar_grid_reporter_if;
   logic [7:0] check_distance;
   logic [2:0] grid;
   logic       grid_valid;
   logic       tx;
   logic       tx_busy;
   modport master (output check_distance, input grid, grid_valid, tx, tx_busy);
   modport slave (input check_distance, output grid, grid_valid, tx, tx_busy);
endinterface

// File: rtl/sonar_grid_reporter.sv
// sonar_grid_reporter: confirms repeated sonar grid measurements and reports them as digit+LF over 8N1 UART
module sonar_grid_reporter #(
   parameter int CLKS_PER_BIT  = 868,
   parameter int CONFIRM_COUNT = 3
) (
   input logic clk,
   input logic reset,
   sonar_grid_reporter_if.slave bus
);
   localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [3:0] CONF = 4'(CONFIRM_COUNT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] prev_code, evt_code, cand, pend, shift, shift_n;
   logic [3:0] match_cnt, cnt_nxt;
   logic [2:0] grid, bit_idx, bit_n;
   logic [CW-1:0] clk_cnt, clk_n;
   logic evt, grid_valid, pend_valid, byte_idx, byte_n, digit, legal, accept, bit_end;
   assign digit = bus.check_distance >= 8'h31 && bus.check_distance <= 8'h34;
   assign legal = bus.check_distance >= 8'h30 && bus.check_distance <= 8'h34;
   assign cnt_nxt = evt_code != cand ? 4'd1 : match_cnt >= CONF ? match_cnt : match_cnt + 4'd1;
   assign accept = evt && cnt_nxt == CONF;
   assign bit_end = clk_cnt == CW'(CLKS_PER_BIT - 1);
   // event is registered so the filter sees it one cycle after the 0x30->digit edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_code  <= 8'h30;
         evt        <= 1'b0;
         evt_code   <= 8'h30;
         cand       <= 8'h30;
         match_cnt  <= 4'd0;
         grid       <= 3'd0;
         grid_valid <= 1'b0;
         pend       <= 8'h30;
         pend_valid <= 1'b0;
      end else begin
         evt        <= prev_code == 8'h30 && digit;
         evt_code   <= bus.check_distance;
         if (legal) prev_code <= bus.check_distance;
         if (evt) begin
            cand      <= evt_code;
            match_cnt <= cnt_nxt;
         end
         grid_valid <= accept;
         if (accept) begin
            grid       <= evt_code[2:0];
            pend       <= evt_code;
            pend_valid <= 1'b1;
         end else if (state == IDLE && pend_valid) begin
            pend_valid <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         shift    <= 8'h00;
         byte_idx <= 1'b0;
         bit_idx  <= 3'd0;
         clk_cnt  <= '0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         byte_idx <= byte_n;
         bit_idx  <= bit_n;
         clk_cnt  <= clk_n;
      end
   end
   always_comb begin
      state_n = state;
      shift_n = shift;
      byte_n  = byte_idx;
      bit_n   = bit_idx;
      clk_n   = (state == IDLE || bit_end) ? '0 : clk_cnt + 1'b1;
      case (state)
         IDLE: if (pend_valid) begin
            shift_n = pend;
            byte_n  = 1'b0;
            state_n = START;
         end
         START: if (bit_end) begin
            bit_n   = 3'd0;
            state_n = DATA;
         end
         DATA: if (bit_end) begin
            bit_n   = bit_idx + 3'd1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_end) begin
            shift_n = byte_idx ? shift : 8'h0A;
            byte_n  = 1'b1;
            state_n = byte_idx ? IDLE : START;
         end
         default: state_n = IDLE;
      endcase
   end
   assign bus.tx         = state == START ? 1'b0 : state == DATA ? shift[bit_idx] : 1'b1;
   assign bus.tx_busy    = state != IDLE;
   assign bus.grid       = grid;
   assign bus.grid_valid = grid_valid;
endmodule

// File: tb/tb_sonar_grid_reporter.sv
// tb_sonar_grid_reporter: randomized checks of sonar_grid_reporter against an event/report-level model
module tb_sonar_grid_reporter;
   localparam int CPB = 4;
   localparam int CC  = 3;
   logic clk = 1'b0;
   logic reset = 1'b0;
   sonar_grid_reporter_if bus();
   sonar_grid_reporter #(.CLKS_PER_BIT(CPB), .CONFIRM_COUNT(CC)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0, n_pass = 0;
   int e, m_prev, ev_d, ev_dc, m_last, run, m_grid, m_gv, pv, pcode, next_free, s, rep_code;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask
   task automatic model_reset();
      e = 0; m_prev = 'h30; ev_d = 0; ev_dc = 'h30; m_last = 'h30; run = 0;
      m_grid = 0; m_gv = 0; pv = 0; pcode = 'h30; next_free = 0; s = -1; rep_code = 0;
   endtask
   function automatic int busy_exp();
      return (s >= 0 && e >= s && e < s + 20*CPB) ? 1 : 0;
   endfunction
   function automatic int tx_exp();
      int o, p, byt;
      if (busy_exp() == 0) return 1;
      o = e - s;
      byt = (o / (10*CPB)) != 0 ? 'h0A : rep_code;
      p = (o % (10*CPB)) / CPB;
      return p == 0 ? 0 : p == 9 ? 1 : (byt >> (p - 1)) & 1;
   endfunction
   // one clock: drive code, apply the model's view of that edge, compare at the falling edge
   task automatic step(input int code);
      int bx, tx_e;
      bus.check_distance = 8'(code);
      @(posedge clk);
      if (e >= next_free && pv != 0) begin
         s = e; rep_code = pcode; next_free = e + 20*CPB + 1; pv = 0;
      end
      m_gv = 0;
      if (ev_d != 0) begin
         run = (ev_dc == m_last) ? run + 1 : 1;
         m_last = ev_dc;
         if (run >= CC) begin m_grid = ev_dc - 'h30; m_gv = 1; pv = 1; pcode = ev_dc; end
      end
      ev_d = (m_prev == 'h30 && code >= 'h31 && code <= 'h34) ? 1 : 0;
      ev_dc = code;
      if (code >= 'h30 && code <= 'h34) m_prev = code;
      bx = busy_exp();
      tx_e = tx_exp();
      e++;
      @(negedge clk);
      check("grid", bus.grid, m_grid);
      check("grid_valid", bus.grid_valid, m_gv);
      check("tx", bus.tx, tx_e);
      check("tx_busy", bus.tx_busy, bx);
   endtask
   task automatic pulse(input int code, input int hold);
      step('h30);
      step('h30);
      repeat (hold) step(code);
   endtask
   task automatic drain();
      int n = 0;
      while ((pv != 0 || busy_exp() != 0) && n < 1000) begin step('h30); n++; end
      step('h30);
      step('h30);
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_tx", bus.tx, 1);
      check("rst_grid", bus.grid, 0);
      check("rst_busy", bus.tx_busy, 0);
      check("rst_gv", bus.grid_valid, 0);
      model_reset();
      bus.check_distance = 8'h30;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask
   initial begin
      int r, code, v, n;
      bus.check_distance = 8'h30;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_grid", bus.grid, 0);
      check("reset_gv", bus.grid_valid, 0);
      check("reset_tx", bus.tx, 1);
      check("reset_busy", bus.tx_busy, 0);
      reset = 1'b1;
      repeat (3) pulse('h32, 2);
      drain();
      pulse('h31, 2); pulse('h31, 3);
      repeat (3) pulse('h33, 2);
      drain();
      pulse('h34, 500);
      repeat (2) pulse('h34, 2);
      drain();
      repeat (3) pulse('h32, 2);
      repeat (20) step('h30);
      pulse('h32, 2);
      repeat (3) pulse('h33, 2);
      drain();
      pulse('h31, 2);
      step('h30); step('h35); step('h30); step('hFF);
      pulse('h31, 2);
      step('h30); step('h00); step('h30); step('h35);
      pulse('h31, 2);
      drain();
      repeat (3) pulse('h31, 2);
      n = 0;
      while (!(s >= 0 && e - s >= 20) && n < 200) begin step('h30); n++; end
      do_reset();
      repeat (3) pulse('h31, 2);
      drain();
      code = 'h31;
      repeat (150) begin
         r = $urandom_range(0, 9);
         if (r >= 6) code = 'h31 + $urandom_range(0, 3);
         pulse(code, $urandom_range(1, 6));
         if (r == 7) repeat (2) step('h31 + $urandom_range(0, 3));
         if (r == 8) begin
            v = $urandom_range(0, 255);
            if (v >= 'h30 && v <= 'h34) v = 'h35;
            step('h30); step(v); step('h30);
         end
         if (r == 9 && $urandom_range(0, 3) == 0) do_reset();
         repeat ($urandom_range(0, 30)) step('h30);
      end
      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
